// File: rtl/dma_peri_mc.sv
// dma_peri_mc: CPU-facing register block for a multi-channel packet DMA.
// Each channel owns a pBufWR and a pBufRD descriptor FIFO, a completion
// pop port, an interrupt enable, a completion counter and a start enable.
// The START arming guard is shared by all channels.
module dma_peri_mc #(
  parameter int CH_NUM     = 2,
  parameter int DESC_DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_peri_rden,
  input  logic                   i_peri_wren,
  input  logic [31:0]            i_peri_addr,
  input  logic [31:0]            i_peri_wdata,
  input  logic [3:0]             i_peri_wstrb,
  output logic [31:0]            o_peri_rdata,
  output logic                   o_peri_ready,
  output logic                   o_peri_int,
  output logic [CH_NUM-1:0]      o_int_ch,
  output logic [CH_NUM-1:0]      o_rden_int,
  input  logic [32*CH_NUM-1:0]   i_dout_int,
  input  logic [CH_NUM-1:0]      i_empty_int,
  output logic [CH_NUM-1:0]      o_desc_wr_valid,
  output logic [48*CH_NUM-1:0]   o_desc_wr_data,
  input  logic [CH_NUM-1:0]      i_desc_wr_ready,
  output logic [CH_NUM-1:0]      o_desc_rd_valid,
  output logic [64*CH_NUM-1:0]   o_desc_rd_data,
  input  logic [CH_NUM-1:0]      i_desc_rd_ready,
  output logic [CH_NUM-1:0]      o_start_en
);
  localparam int AW = $clog2(DESC_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] RD_INVALID = 32'h8000_0000;

  logic [1:0]            ch_sel;
  logic [3:0]            reg_sel;
  logic                  ch_ok;
  logic                  wr_ok;
  logic                  unused_addr;
  logic [31:0]           rd_val;
  logic [CH_NUM-1:0]     pop_req;
  logic [32*CH_NUM-1:0]  wr_addr_v;
  logic [32*CH_NUM-1:0]  rd_addr_v;
  logic [8*CH_NUM-1:0]   cnt_v;
  logic [8*CH_NUM-1:0]   wr_free_v;
  logic [8*CH_NUM-1:0]   rd_free_v;
  logic [CH_NUM-1:0]     wr_ovf_v;
  logic [CH_NUM-1:0]     rd_ovf_v;
  logic [CH_NUM-1:0]     int_en;
  logic                  guard;

  assign ch_sel      = i_peri_addr[7:6];
  assign reg_sel     = i_peri_addr[5:2];
  assign ch_ok       = int'(ch_sel) < CH_NUM;
  assign wr_ok       = i_peri_wren && (i_peri_wstrb == 4'hF) && ch_ok;
  assign unused_addr = ^{i_peri_addr[31:8], i_peri_addr[1:0]};

  assign o_int_ch   = ~i_empty_int & int_en;
  assign o_peri_int = |o_int_ch;

  // Read data mux for the addressed channel; also flags a completion pop.
  always_comb begin
    rd_val  = RD_INVALID;
    pop_req = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (ch_sel == 2'(c)) begin
        case (reg_sel)
          4'd0: if (!i_empty_int[c]) begin
                  rd_val     = i_dout_int[32*c +: 32];
                  pop_req[c] = 1'b1;
                end
          4'd1: rd_val = wr_addr_v[32*c +: 32];
          4'd2: rd_val = '0;
          4'd3: rd_val = rd_addr_v[32*c +: 32];
          4'd4: rd_val = '0;
          4'd5: rd_val = {wr_free_v[8*c +: 8], rd_free_v[8*c +: 8], 14'd0,
                          rd_ovf_v[c], wr_ovf_v[c]};
          4'd6: rd_val = {31'd0, int_en[c]};
          4'd7: rd_val = {31'd0, o_start_en[c]};
          4'd8: rd_val = {24'd0, cnt_v[8*c +: 8]};
          default: rd_val = RD_INVALID;
        endcase
      end
    end
  end

  // Bus acknowledge, read capture, and the shared per-channel registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_peri_rdata <= '0;
      o_peri_ready <= 1'b0;
      o_rden_int   <= '0;
      o_start_en   <= '0;
      int_en       <= '0;
      guard        <= 1'b0;
      cnt_v        <= '0;
      wr_addr_v    <= '0;
      rd_addr_v    <= '0;
    end else begin
      o_peri_ready <= i_peri_rden | i_peri_wren;
      o_rden_int   <= i_peri_rden ? pop_req : '0;
      if (i_peri_rden) o_peri_rdata <= rd_val;
      // Any effective write other than an arming START write drops the guard.
      if (wr_ok) begin
        if (reg_sel == 4'd7) guard <= guard ? 1'b0 : (i_peri_wdata == 32'h0000_1234);
        else                 guard <= 1'b0;
      end
      for (int c = 0; c < CH_NUM; c++) begin
        if (i_peri_rden && pop_req[c]) begin
          cnt_v[8*c +: 8] <= cnt_v[8*c +: 8] + 8'd1;
        end
        if (wr_ok && ch_sel == 2'(c)) begin
          case (reg_sel)
            4'd1: wr_addr_v[32*c +: 32] <= i_peri_wdata;
            4'd3: rd_addr_v[32*c +: 32] <= i_peri_wdata;
            4'd6: int_en[c] <= i_peri_wdata[0];
            4'd7: if (guard) o_start_en[c] <= i_peri_wdata[0];
            4'd8: cnt_v[8*c +: 8] <= i_peri_wdata[7:0];
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic          hit;
    logic          wr_push, wr_pop, wr_full, wr_push_ok;
    logic          rd_push, rd_pop, rd_full, rd_push_ok;
    logic [AW-1:0] wr_wp, wr_rp, rd_wp, rd_rp;
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic [47:0]   wr_mem [DESC_DEPTH];
    logic [63:0]   rd_mem [DESC_DEPTH];

    assign hit     = (ch_sel == 2'(c));
    assign wr_push = wr_ok && hit && (reg_sel == 4'd2);
    assign rd_push = wr_ok && hit && (reg_sel == 4'd4);
    assign wr_pop  = o_desc_wr_valid[c] && i_desc_wr_ready[c];
    assign rd_pop  = o_desc_rd_valid[c] && i_desc_rd_ready[c];
    assign wr_full = (wr_cnt == CW'(DESC_DEPTH));
    assign rd_full = (rd_cnt == CW'(DESC_DEPTH));
    // A pop in the same cycle frees the slot the full-FIFO push lands in.
    assign wr_push_ok = wr_push && (!wr_full || wr_pop);
    assign rd_push_ok = rd_push && (!rd_full || rd_pop);

    assign o_desc_wr_valid[c]          = (wr_cnt != '0);
    assign o_desc_rd_valid[c]          = (rd_cnt != '0);
    assign o_desc_wr_data[48*c +: 48]  = wr_mem[wr_rp];
    assign o_desc_rd_data[64*c +: 64]  = rd_mem[rd_rp];
    assign wr_free_v[8*c +: 8]         = 8'(DESC_DEPTH) - 8'(wr_cnt);
    assign rd_free_v[8*c +: 8]         = 8'(DESC_DEPTH) - 8'(rd_cnt);

    // Descriptor storage; contents are don't-care until pointed at.
    always_ff @(posedge i_clk) begin
      if (wr_push_ok) wr_mem[wr_wp] <= {i_peri_wdata[15:0], wr_addr_v[32*c +: 32]};
      if (rd_push_ok) rd_mem[rd_wp] <= {rd_addr_v[32*c +: 32], i_peri_wdata};
    end

    // FIFO pointers, occupancy and sticky overflow flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        wr_wp <= '0; wr_rp <= '0; wr_cnt <= '0; wr_ovf_v[c] <= 1'b0;
        rd_wp <= '0; rd_rp <= '0; rd_cnt <= '0; rd_ovf_v[c] <= 1'b0;
      end else begin
        if (wr_push_ok) wr_wp <= AW'(wr_wp + 1);
        if (wr_pop)     wr_rp <= AW'(wr_rp + 1);
        if (wr_push_ok && !wr_pop)      wr_cnt <= CW'(wr_cnt + 1);
        else if (!wr_push_ok && wr_pop) wr_cnt <= CW'(wr_cnt - 1);
        if (rd_push_ok) rd_wp <= AW'(rd_wp + 1);
        if (rd_pop)     rd_rp <= AW'(rd_rp + 1);
        if (rd_push_ok && !rd_pop)      rd_cnt <= CW'(rd_cnt + 1);
        else if (!rd_push_ok && rd_pop) rd_cnt <= CW'(rd_cnt - 1);
        if (wr_push && !wr_push_ok) wr_ovf_v[c] <= 1'b1;
        else if (wr_ok && hit && reg_sel == 4'd5 && i_peri_wdata[0]) wr_ovf_v[c] <= 1'b0;
        if (rd_push && !rd_push_ok) rd_ovf_v[c] <= 1'b1;
        else if (wr_ok && hit && reg_sel == 4'd5 && i_peri_wdata[1]) rd_ovf_v[c] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_peri_mc.sv
// Directed bench for dma_peri_mc with CH_NUM=2, DESC_DEPTH=8.
module tb_dma_peri_mc;
  localparam int CH_NUM = 2;

  logic                 i_clk, i_rst;
  logic                 i_peri_rden, i_peri_wren;
  logic [31:0]          i_peri_addr, i_peri_wdata;
  logic [3:0]           i_peri_wstrb;
  logic [31:0]          o_peri_rdata;
  logic                 o_peri_ready, o_peri_int;
  logic [CH_NUM-1:0]    o_int_ch, o_rden_int;
  logic [32*CH_NUM-1:0] i_dout_int;
  logic [CH_NUM-1:0]    i_empty_int;
  logic [CH_NUM-1:0]    o_desc_wr_valid, i_desc_wr_ready;
  logic [48*CH_NUM-1:0] o_desc_wr_data;
  logic [CH_NUM-1:0]    o_desc_rd_valid, i_desc_rd_ready;
  logic [64*CH_NUM-1:0] o_desc_rd_data;
  logic [CH_NUM-1:0]    o_start_en;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd;

  dma_peri_mc #(.CH_NUM(2), .DESC_DEPTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_peri_rden(i_peri_rden), .i_peri_wren(i_peri_wren),
    .i_peri_addr(i_peri_addr), .i_peri_wdata(i_peri_wdata), .i_peri_wstrb(i_peri_wstrb),
    .o_peri_rdata(o_peri_rdata), .o_peri_ready(o_peri_ready), .o_peri_int(o_peri_int),
    .o_int_ch(o_int_ch), .o_rden_int(o_rden_int),
    .i_dout_int(i_dout_int), .i_empty_int(i_empty_int),
    .o_desc_wr_valid(o_desc_wr_valid), .o_desc_wr_data(o_desc_wr_data),
    .i_desc_wr_ready(i_desc_wr_ready),
    .o_desc_rd_valid(o_desc_rd_valid), .o_desc_rd_data(o_desc_rd_data),
    .i_desc_rd_ready(i_desc_rd_ready),
    .o_start_en(o_start_en)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input int ch, input int rg, input logic [31:0] d,
                           input logic [3:0] s = 4'hF);
    i_peri_addr  = {24'd0, 2'(ch), 4'(rg), 2'b00};
    i_peri_wdata = d;
    i_peri_wstrb = s;
    i_peri_wren  = 1'b1;
    @(posedge i_clk); #1;
    i_peri_wren  = 1'b0;
  endtask

  task automatic bus_read(input int ch, input int rg, output logic [31:0] d);
    i_peri_addr = {24'd0, 2'(ch), 4'(rg), 2'b00};
    i_peri_rden = 1'b1;
    @(posedge i_clk); #1;
    i_peri_rden = 1'b0;
    d = o_peri_rdata;
  endtask

  initial begin
    i_rst = 1'b1;
    i_peri_rden = 0; i_peri_wren = 0; i_peri_addr = 0; i_peri_wdata = 0; i_peri_wstrb = 0;
    i_dout_int = '0; i_empty_int = 2'b11;
    i_desc_wr_ready = '0; i_desc_rd_ready = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_rdata", o_peri_rdata, 0);
    check("rst_ready", o_peri_ready, 0);
    check("rst_valids", {o_desc_wr_valid, o_desc_rd_valid}, 0);
    check("rst_start_rden", {o_start_en, o_rden_int, o_int_ch, o_peri_int}, 0);
    i_rst = 1'b0;

    // Reset STATUS
    bus_read(0, 5, rd);
    check("status_reset", rd, 32'h0808_0000);
    check("ready_ack", o_peri_ready, 1);

    // ch1 WR descriptor with ready held low
    bus_write(1, 1, 32'h1000_0040);
    bus_write(1, 2, 32'h0000_05EA);
    check("wr1_valid", o_desc_wr_valid, 2'b10);
    check("wr1_data", o_desc_wr_data[95:48], {16'h05EA, 32'h1000_0040});
    bus_read(1, 1, rd);
    check("wr1_addr_rb", rd, 32'h1000_0040);
    bus_read(1, 5, rd);
    check("status_ch1", rd, 32'h0708_0000);
    i_desc_wr_ready[1] = 1'b1;
    @(posedge i_clk); #1;
    i_desc_wr_ready[1] = 1'b0;
    check("wr1_valid_drop", o_desc_wr_valid, 2'b00);

    // ch0 RD FIFO overflow
    bus_write(0, 3, 32'hA000_0000);
    for (int i = 0; i < 9; i++) bus_write(0, 4, i);
    check("rd0_head", o_desc_rd_data[63:0], {32'hA000_0000, 32'd0});
    bus_read(0, 5, rd);
    check("status_ovf", rd, 32'h0800_0002);
    bus_write(0, 5, 32'h2);
    bus_read(0, 5, rd);
    check("status_ovf_clr", rd, 32'h0800_0000);
    // push while full with a same-cycle pop
    i_desc_rd_ready[0] = 1'b1;
    bus_write(0, 4, 32'h99);
    i_desc_rd_ready[0] = 1'b0;
    bus_read(0, 5, rd);
    check("status_full_pushpop", rd, 32'h0800_0000);
    i_desc_rd_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("rd0_order", o_desc_rd_data[63:0],
            {32'hA000_0000, (i < 7) ? 32'(i + 1) : 32'h99});
      @(posedge i_clk); #1;
    end
    i_desc_rd_ready[0] = 1'b0;
    check("rd0_drained", o_desc_rd_valid, 2'b00);

    // Completion pop and counter
    i_dout_int[31:0] = 32'h8000_0123;
    i_empty_int[0] = 1'b0;
    bus_read(0, 0, rd);
    check("int_head", rd, 32'h8000_0123);
    check("rden_pulse", o_rden_int, 2'b01);
    i_empty_int[0] = 1'b1;
    bus_read(0, 8, rd);
    check("cnt_one", rd, 32'd1);
    check("rden_single", o_rden_int, 2'b00);
    bus_read(0, 0, rd);
    check("int_empty", rd, 32'h8000_0000);
    check("rden_none", o_rden_int, 2'b00);
    bus_write(0, 8, 32'h0000_0000, 4'h3);
    bus_read(0, 8, rd);
    check("cnt_partial_strb", rd, 32'd1);
    bus_write(0, 8, 32'hFF);
    i_empty_int[0] = 1'b0;
    bus_read(0, 0, rd);
    i_empty_int[0] = 1'b1;
    bus_read(0, 8, rd);
    check("cnt_wrap", rd, 32'd0);

    // Guarded start
    bus_write(1, 7, 32'h1);
    check("start_unarmed", o_start_en, 2'b00);
    bus_write(0, 7, 32'h1234);
    bus_write(1, 7, 32'h1);
    check("start_armed", o_start_en, 2'b10);
    bus_read(1, 7, rd);
    check("start_rb", rd, 32'd1);
    bus_write(1, 7, 32'h0);
    check("start_disarmed", o_start_en, 2'b10);
    bus_write(0, 7, 32'h1234);
    bus_write(0, 6, 32'h0);
    bus_write(0, 7, 32'h1);
    check("start_other_disarm", o_start_en, 2'b10);

    // Interrupts and invalid channel
    i_empty_int = 2'b01;
    bus_write(1, 6, 32'h1);
    check("int_ch", o_int_ch, 2'b10);
    check("peri_int", o_peri_int, 1);
    bus_write(1, 6, 32'h0);
    check("int_cleared", {o_int_ch, o_peri_int}, 0);
    bus_read(3, 0, rd);
    check("bad_channel", rd, 32'h8000_0000);
    bus_read(0, 12, rd);
    check("bad_reg", rd, 32'h8000_0000);

    // Reset mid-operation discards queued descriptors
    bus_write(0, 2, 32'h10);
    check("pre_reset_valid", o_desc_wr_valid, 2'b01);
    i_rst = 1'b1;
    #2;
    check("mid_reset_valid", {o_desc_wr_valid, o_start_en}, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    bus_read(0, 5, rd);
    check("post_reset_status", rd, 32'h0808_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
